// File: rtl/alu_operand_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_operand_stage_if
//  Brief    : Decode-side, forwarding and ALU-side signal bundle for the
//             ID/EX operand stage. The master modport is the surrounding
//             pipeline (decode, forwarding sources, execute); the slave
//             modport is the operand stage itself.
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_operand_stage_if #(
    parameter int N = 32,
    parameter int A = 5
);
    // Decode side
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_rs1_data;
    logic [N-1:0] in_rs2_data;
    logic [A-1:0] in_rs1_addr;
    logic [A-1:0] in_rs2_addr;
    logic [A-1:0] in_rd_addr;
    logic [N-1:0] in_imm;
    logic         in_use_imm;
    logic [3:0]   in_alu_op;
    logic         in_reg_write;
    logic         flush;
    // Forwarding sources
    logic         ex_fwd_en;
    logic [A-1:0] ex_fwd_rd;
    logic [N-1:0] ex_fwd_data;
    logic         wb_fwd_en;
    logic [A-1:0] wb_fwd_rd;
    logic [N-1:0] wb_fwd_data;
    // ALU side
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] read_data_1;
    logic [N-1:0] read_data_2;
    logic [3:0]   OpCode;
    logic [A-1:0] out_rd_addr;
    logic         out_reg_write;

    modport master (
        output in_valid, in_rs1_data, in_rs2_data, in_rs1_addr, in_rs2_addr,
               in_rd_addr, in_imm, in_use_imm, in_alu_op, in_reg_write, flush,
               ex_fwd_en, ex_fwd_rd, ex_fwd_data,
               wb_fwd_en, wb_fwd_rd, wb_fwd_data, out_ready,
        input  in_ready, out_valid, read_data_1, read_data_2, OpCode,
               out_rd_addr, out_reg_write
    );

    modport slave (
        input  in_valid, in_rs1_data, in_rs2_data, in_rs1_addr, in_rs2_addr,
               in_rd_addr, in_imm, in_use_imm, in_alu_op, in_reg_write, flush,
               ex_fwd_en, ex_fwd_rd, ex_fwd_data,
               wb_fwd_en, wb_fwd_rd, wb_fwd_data, out_ready,
        output in_ready, out_valid, read_data_1, read_data_2, OpCode,
               out_rd_addr, out_reg_write
    );
endinterface
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_operand_stage
//  Brief    : ID/EX pipeline register in front of the ALU. Captures decoded
//             operands with forwarding applied, re-forwards them on the way
//             out, and refreshes held operands while stalled so a producer
//             that retires during the stall is never lost.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_operand_stage #(
    parameter int N = 32,
    parameter int A = 5
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    alu_operand_stage_if.slave bus
);

    // EX/MEM result beats MEM/WB; register x0 is never forwarded.
    function automatic logic [N-1:0] fwd_value(
        input logic [A-1:0] addr,
        input logic [N-1:0] base,
        input logic         ex_en,
        input logic [A-1:0] ex_rd,
        input logic [N-1:0] ex_data,
        input logic         wb_en,
        input logic [A-1:0] wb_rd,
        input logic [N-1:0] wb_data
    );
        logic [N-1:0] result;
        result = base;
        if (ex_en && (ex_rd == addr) && (addr != '0)) begin
            result = ex_data;
        end else if (wb_en && (wb_rd == addr) && (addr != '0)) begin
            result = wb_data;
        end
        return result;
    endfunction

    logic         valid_q,     valid_d;
    logic [A-1:0] rs1_addr_q,  rs1_addr_d;
    logic [A-1:0] rs2_addr_q,  rs2_addr_d;
    logic [N-1:0] rs1_data_q,  rs1_data_d;
    logic [N-1:0] rs2_data_q,  rs2_data_d;
    logic [N-1:0] imm_q,       imm_d;
    logic         use_imm_q,   use_imm_d;
    logic [3:0]   alu_op_q,    alu_op_d;
    logic [A-1:0] rd_addr_q,   rd_addr_d;
    logic         reg_write_q, reg_write_d;

    logic         w_in_ready;
    logic         w_load;
    logic         w_xfer;
    logic [N-1:0] w_load_rs1;
    logic [N-1:0] w_load_rs2;
    logic [N-1:0] w_out_rs1;
    logic [N-1:0] w_out_rs2;

    assign w_in_ready = !valid_q || bus.out_ready;
    assign w_load     = bus.in_valid && w_in_ready && !bus.flush;
    assign w_xfer     = valid_q && bus.out_ready;

    assign w_load_rs1 = fwd_value(bus.in_rs1_addr, bus.in_rs1_data,
                                  bus.ex_fwd_en, bus.ex_fwd_rd, bus.ex_fwd_data,
                                  bus.wb_fwd_en, bus.wb_fwd_rd, bus.wb_fwd_data);
    assign w_load_rs2 = fwd_value(bus.in_rs2_addr, bus.in_rs2_data,
                                  bus.ex_fwd_en, bus.ex_fwd_rd, bus.ex_fwd_data,
                                  bus.wb_fwd_en, bus.wb_fwd_rd, bus.wb_fwd_data);
    assign w_out_rs1  = fwd_value(rs1_addr_q, rs1_data_q,
                                  bus.ex_fwd_en, bus.ex_fwd_rd, bus.ex_fwd_data,
                                  bus.wb_fwd_en, bus.wb_fwd_rd, bus.wb_fwd_data);
    assign w_out_rs2  = fwd_value(rs2_addr_q, rs2_data_q,
                                  bus.ex_fwd_en, bus.ex_fwd_rd, bus.ex_fwd_data,
                                  bus.wb_fwd_en, bus.wb_fwd_rd, bus.wb_fwd_data);

    // Next state: flush beats load, load beats drain, a stall refreshes operands.
    always_comb begin
        valid_d     = valid_q;
        rs1_addr_d  = rs1_addr_q;
        rs2_addr_d  = rs2_addr_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        use_imm_d   = use_imm_q;
        alu_op_d    = alu_op_q;
        rd_addr_d   = rd_addr_q;
        reg_write_d = reg_write_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (w_load) begin
            valid_d     = 1'b1;
            rs1_addr_d  = bus.in_rs1_addr;
            rs2_addr_d  = bus.in_rs2_addr;
            rs1_data_d  = w_load_rs1;
            rs2_data_d  = w_load_rs2;
            imm_d       = bus.in_imm;
            use_imm_d   = bus.in_use_imm;
            alu_op_d    = bus.in_alu_op;
            rd_addr_d   = bus.in_rd_addr;
            reg_write_d = bus.in_reg_write;
        end else if (w_xfer) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            rs1_data_d = w_out_rs1;
            rs2_data_d = w_out_rs2;
        end
    end

    // Pipeline register with asynchronous clear of all stored fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            alu_op_q    <= '0;
            rd_addr_q   <= '0;
            reg_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            rs1_addr_q  <= rs1_addr_d;
            rs2_addr_q  <= rs2_addr_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            use_imm_q   <= use_imm_d;
            alu_op_q    <= alu_op_d;
            rd_addr_q   <= rd_addr_d;
            reg_write_q <= reg_write_d;
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = valid_q;
    assign bus.read_data_1   = w_out_rs1;
    assign bus.read_data_2   = use_imm_q ? imm_q : w_out_rs2;
    assign bus.OpCode        = alu_op_q;
    assign bus.out_rd_addr   = rd_addr_q;
    assign bus.out_reg_write = reg_write_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_operand_stage
//  Brief    : Scoreboard bench for alu_operand_stage. The issue side pushes
//             the expected instruction when the stage accepts it; a monitor
//             compares it against the ALU-side outputs each cycle, treating
//             each held operand as "latest value produced for that register".
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;

    localparam int N = 32;
    localparam int A = 5;

    typedef struct {
        logic [A-1:0] rs1_addr;
        logic [N-1:0] rs1_val;
        logic [A-1:0] rs2_addr;
        logic [N-1:0] rs2_val;
        logic         use_imm;
        logic [N-1:0] imm;
        logic [3:0]   op;
        logic [A-1:0] rd;
        logic         rw;
    } entry_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    entry_t sb[$];
    int     checks = 0;
    int     failures = 0;

    alu_operand_stage_if #(.N(N), .A(A)) bus ();

    alu_operand_stage #(.N(N), .A(A)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Most recent value of register a visible on the forwarding buses.
    function automatic logic [N-1:0] resolve(input logic [A-1:0] a, input logic [N-1:0] base);
        if (a != 0 && bus.ex_fwd_en && bus.ex_fwd_rd == a) return bus.ex_fwd_data;
        if (a != 0 && bus.wb_fwd_en && bus.wb_fwd_rd == a) return bus.wb_fwd_data;
        return base;
    endfunction

    task automatic idle();
        bus.in_valid = 1'b0;     bus.in_rs1_data = '0;  bus.in_rs2_data = '0;
        bus.in_rs1_addr = '0;    bus.in_rs2_addr = '0;  bus.in_rd_addr = '0;
        bus.in_imm = '0;         bus.in_use_imm = 1'b0; bus.in_alu_op = '0;
        bus.in_reg_write = 1'b0; bus.flush = 1'b0;
        bus.ex_fwd_en = 1'b0;    bus.ex_fwd_rd = '0;    bus.ex_fwd_data = '0;
        bus.wb_fwd_en = 1'b0;    bus.wb_fwd_rd = '0;    bus.wb_fwd_data = '0;
        bus.out_ready = 1'b0;
    endtask

    // Called at posedge+1 with inputs set; pushes the issued instruction
    // if accepted and returns at the next posedge+1.
    task automatic step();
        entry_t e;
        @(negedge clk);
        #1;
        if (rst_n && bus.in_valid && !bus.flush && sb.size() == 0) begin
            e.rs1_addr = bus.in_rs1_addr;
            e.rs1_val  = resolve(bus.in_rs1_addr, bus.in_rs1_data);
            e.rs2_addr = bus.in_rs2_addr;
            e.rs2_val  = resolve(bus.in_rs2_addr, bus.in_rs2_data);
            e.use_imm  = bus.in_use_imm;
            e.imm      = bus.in_imm;
            e.op       = bus.in_alu_op;
            e.rd       = bus.in_rd_addr;
            e.rw       = bus.in_reg_write;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare at mid-cycle, then retire / kill / refresh the head.
    initial begin
        entry_t h;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("out_valid", bus.out_valid, sb.size() != 0);
                chk("in_ready", bus.in_ready, (sb.size() == 0) || bus.out_ready);
                if (sb.size() != 0 && bus.out_valid) begin
                    h = sb[0];
                    chk("read_data_1", bus.read_data_1, resolve(h.rs1_addr, h.rs1_val));
                    chk("read_data_2", bus.read_data_2,
                        h.use_imm ? h.imm : resolve(h.rs2_addr, h.rs2_val));
                    chk("OpCode", bus.OpCode, h.op);
                    chk("dest", {bus.out_rd_addr, bus.out_reg_write}, {h.rd, h.rw});
                end
                if (sb.size() != 0) begin
                    if (bus.out_ready || bus.flush) begin
                        void'(sb.pop_front());
                    end else begin
                        sb[0].rs1_val = resolve(sb[0].rs1_addr, sb[0].rs1_val);
                        sb[0].rs2_val = resolve(sb[0].rs2_addr, sb[0].rs2_val);
                    end
                end
            end
        end
    end

    logic [3:0] ops [4];

    initial begin
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_valid", bus.out_valid, 1'b0);
        chk("reset_fields", {bus.read_data_1, bus.read_data_2, bus.OpCode,
                             bus.out_rd_addr, bus.out_reg_write}, '0);
        rst_n = 1'b1;
        step();
        chk("ready_after_reset", bus.in_ready, 1'b1);

        // Reset then load
        bus.in_valid = 1'b1; bus.in_rs1_addr = 5'd1; bus.in_rs2_addr = 5'd2;
        bus.in_rs1_data = 32'd5; bus.in_rs2_data = 32'd7; bus.in_alu_op = 4'b0100;
        step();
        idle();
        chk("load_valid", bus.out_valid, 1'b1);
        chk("load_rd1", bus.read_data_1, 32'd5);
        chk("load_rd2", bus.read_data_2, 32'd7);
        chk("load_op", bus.OpCode, 4'b0100);

        // Forwarding priority, then the x0 exception
        bus.out_ready = 1'b1; bus.in_valid = 1'b1;
        bus.in_rs1_addr = 5'd3; bus.in_rs1_data = 32'd1;
        bus.ex_fwd_en = 1'b1; bus.ex_fwd_rd = 5'd3; bus.ex_fwd_data = 32'hAA;
        bus.wb_fwd_en = 1'b1; bus.wb_fwd_rd = 5'd3; bus.wb_fwd_data = 32'hBB;
        step();
        chk("prio_ex_over_wb", bus.read_data_1, 32'hAA);
        bus.in_rs1_addr = 5'd0; bus.ex_fwd_rd = 5'd0; bus.wb_fwd_rd = 5'd0;
        step();
        chk("x0_no_forward", bus.read_data_1, 32'd1);

        // Stall refresh: WB result appears for one cycle during a stall
        idle();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_rs2_addr = 5'd4; bus.in_rs2_data = 32'd0;
        step();
        idle();
        bus.wb_fwd_en = 1'b1; bus.wb_fwd_rd = 5'd4; bus.wb_fwd_data = 32'h55;
        step();
        bus.wb_fwd_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_refresh", bus.read_data_2, 32'h55);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        chk("stall_drained", bus.out_valid, 1'b0);

        // Immediate overrides a forwarding hit on rs2
        bus.in_valid = 1'b1; bus.in_use_imm = 1'b1; bus.in_imm = 32'hFFFF_FFF0;
        bus.in_rs2_addr = 5'd2; bus.in_rs2_data = 32'h1234;
        bus.ex_fwd_en = 1'b1; bus.ex_fwd_rd = 5'd2; bus.ex_fwd_data = 32'hDEAD;
        step();
        chk("imm_select", bus.read_data_2, 32'hFFFF_FFF0);

        // Flush beats an incoming load
        idle();
        bus.in_valid = 1'b1; bus.in_alu_op = 4'd3; bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0; bus.flush = 1'b1; bus.in_alu_op = 4'd6;
        step();
        idle();
        chk("flush_valid", bus.out_valid, 1'b0);
        chk("flush_ready", bus.in_ready, 1'b1);

        // Back-to-back, then asynchronous reset mid-stream
        ops[0] = 4'd1; ops[1] = 4'd2; ops[2] = 4'd4; ops[3] = 4'd9;
        bus.out_ready = 1'b1; bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_alu_op = ops[i];
            step();
            chk("b2b_valid", bus.out_valid, 1'b1);
            chk("b2b_op", bus.OpCode, ops[i]);
        end
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("async_reset_valid", bus.out_valid, 1'b0);
        idle();
        step();
        rst_n = 1'b1;
        step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bus.in_valid     = ($urandom_range(0, 3) != 0);
            bus.in_rs1_addr  = A'($urandom_range(0, 3));
            bus.in_rs2_addr  = A'($urandom_range(0, 3));
            bus.in_rd_addr   = A'($urandom_range(0, 31));
            bus.in_rs1_data  = $urandom;
            bus.in_rs2_data  = $urandom;
            bus.in_imm       = $urandom;
            bus.in_use_imm   = ($urandom_range(0, 3) == 0);
            bus.in_alu_op    = 4'($urandom_range(0, 15));
            bus.in_reg_write = 1'($urandom_range(0, 1));
            bus.flush        = ($urandom_range(0, 15) == 0);
            bus.ex_fwd_en    = 1'($urandom_range(0, 1));
            bus.ex_fwd_rd    = A'($urandom_range(0, 3));
            bus.ex_fwd_data  = $urandom;
            bus.wb_fwd_en    = 1'($urandom_range(0, 1));
            bus.wb_fwd_rd    = A'($urandom_range(0, 3));
            bus.wb_fwd_data  = $urandom;
            bus.out_ready    = ($urandom_range(0, 9) < 6);
            step();
        end

        idle();
        bus.out_ready = 1'b1;
        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
